fifo_ff_reader: RTL and testbench

- Read-side drain engine for the fifo_ff_sync_* FIFOs. Drives the FIFO read port (rd_en, empty, rd_data) and presents the words on a valid/ready stream with registered outputs.
- Tracks reads still in flight through the FIFO read latency, so it works with both combinational-read and registered-read FIFO variants.
- Provides a small output buffer so that backpressure on out_ready never loses or duplicates a word.

---
 rtl/fifo_ff_reader_if.sv | 24 ++
 rtl/fifo_ff_reader.sv | 76 +++++++
 tb/tb_fifo_ff_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ff_reader_if.sv
// Read-port and output-stream bundle for fifo_ff_reader.
// master = the reader engine, slave = the FIFO/consumer side.
interface fifo_ff_reader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 2
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] buf_cnt;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, buf_cnt
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, buf_cnt
    );
endinterface

// File: rtl/fifo_ff_reader.sv
// Drains a fifo_ff_sync_* read port into a registered valid/ready stream; first word RD_LAT+1 cycles after rd_en.
// Backpressure is absorbed by a BUF_DEPTH-entry buffer; reads are throttled on occupancy plus in-flight reads.
module fifo_ff_reader #(
    parameter int WIDTH     = 32,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    fifo_ff_reader_if.master  rd
);
    localparam int              PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(BUF_DEPTH);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             pend_eff;
    logic [CNT_W:0]   occ;
    logic             rd_en;
    logic             push;
    logic             pop;
    logic             out_vld;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Reads still travelling through the FIFO count against buffer space.
    assign pend_eff = (RD_LAT == 1) ? pend_q : 1'b0;
    assign occ      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_eff};
    assign rd_en    = rst_n && !rd.fifo_empty && !flush && (occ < DEPTH_C);
    assign push     = !flush && ((RD_LAT == 0) ? rd_en : pend_q);
    assign out_vld  = (cnt_q != '0);
    assign pop      = !flush && out_vld && rd.out_ready;

    assign rd.fifo_rd_en = rd_en;
    assign rd.out_valid  = out_vld;
    assign rd.out_data   = mem_q[head_q];
    assign rd.buf_cnt    = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            // Anything buffered or landing this cycle is dropped.
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pend_q <= (RD_LAT == 1) ? rd_en : 1'b0;
            if (push) begin
                mem_q[tail_q] <= rd.fifo_rd_data;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop) head_q <= ptr_inc(head_q);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (cnt_q == FULL_C)));

endmodule

// File: tb/tb_fifo_ff_reader.sv
// Bench for fifo_ff_reader: registered-read (RD_LAT=1, depth 3) and combinational-read (RD_LAT=0, depth 2) instances,
// each fed by a queue-based FIFO model, with scoreboard monitors checking stream order.
module tb_fifo_ff_reader;
    logic clk = 1'b0;
    logic rst_n;
    logic flush1;
    logic flush0;

    always #5 clk = ~clk;

    fifo_ff_reader_if #(.WIDTH(32), .CNT_W(2)) b1 ();
    fifo_ff_reader_if #(.WIDTH(32), .CNT_W(2)) b0 ();

    fifo_ff_reader #(.WIDTH(32), .RD_LAT(1), .BUF_DEPTH(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .rd(b1)
    );
    fifo_ff_reader #(.WIDTH(32), .RD_LAT(0), .BUF_DEPTH(2), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .rd(b0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fq1 [$];
    logic [31:0] fq0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] exp0 [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq1.push_back(base + 32'(i));
            exp1.push_back(base + 32'(i));
        end
    endtask

    task automatic load0(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq0.push_back(base + 32'(i));
            exp0.push_back(base + 32'(i));
        end
    endtask

    // Registered-read FIFO model: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (!rst_n) b1.fifo_rd_data <= '0;
        else if (b1.fifo_rd_en) b1.fifo_rd_data <= fq1.pop_front();
        b1.fifo_empty <= (fq1.size() == 0);
    end

    // Combinational-read FIFO model: head word is always presented.
    always @(posedge clk) begin
        if (rst_n && b0.fifo_rd_en) void'(fq0.pop_front());
        b0.fifo_rd_data <= (fq0.size() != 0) ? fq0[0] : 32'h0;
        b0.fifo_empty   <= (fq0.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n && b1.out_valid && b1.out_ready && !flush1) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_extra_word: got 0x%0h, required no word", b1.out_data);
            end else begin
                chk("d1_order", 64'(b1.out_data), 64'(exp1.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b0.out_valid && b0.out_ready && !flush0) begin
            if (exp0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_extra_word: got 0x%0h, required no word", b0.out_data);
            end else begin
                chk("d0_order", 64'(b0.out_data), 64'(exp0.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        int vcnt;
        int bad;

        rst_n        = 1'b0;
        flush1       = 1'b0;
        flush0       = 1'b0;
        b1.out_ready = 1'b1;
        b0.out_ready = 1'b1;
        load1(32'h10, 8);
        repeat (3) tick();

        chk("rst_empty_setup", 64'(b1.fifo_empty), 64'd0);
        chk("rst_rd_en", 64'(b1.fifo_rd_en), 64'd0);
        chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
        chk("rst_out_data", 64'(b1.out_data), 64'd0);
        chk("rst_buf_cnt", 64'(b1.buf_cnt), 64'd0);

        // Streaming, RD_LAT=1
        rst_n = 1'b1;
        #1;
        chk("rel_rd_en", 64'(b1.fifo_rd_en), 64'd1);
        tick();
        chk("stream_lat_n1", 64'(b1.out_valid), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b1.out_valid) vcnt++;
        end
        chk("stream_no_gaps", 64'(vcnt), 64'd8);
        tick();
        chk("stream_done_valid", 64'(b1.out_valid), 64'd0);
        chk("stream_done_cnt", 64'(b1.buf_cnt), 64'd0);

        // Backpressure
        b1.out_ready = 1'b0;
        load1(32'h10, 8);
        pulses = 0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b1.fifo_rd_en) pulses++;
            if (b1.out_valid && b1.out_data !== 32'h10) bad++;
        end
        chk("bp_rd_pulses", 64'(pulses), 64'd3);
        chk("bp_buf_cnt", 64'(b1.buf_cnt), 64'd3);
        chk("bp_out_valid", 64'(b1.out_valid), 64'd1);
        chk("bp_out_data", 64'(b1.out_data), 64'h10);
        chk("bp_head_stable", 64'(bad), 64'd0);
        b1.out_ready = 1'b1;
        for (int i = 0; i < 40 && exp1.size() != 0; i++) tick();
        chk("bp_drained", 64'(exp1.size()), 64'd0);
        repeat (2) tick();
        chk("bp_final_cnt", 64'(b1.buf_cnt), 64'd0);

        // Empty mid-stream
        load1(32'h20, 2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b1.fifo_rd_en) pulses++;
        end
        chk("empty_rd_pulses", 64'(pulses), 64'd2);
        chk("empty_words_out", 64'(exp1.size()), 64'd0);
        chk("empty_out_valid", 64'(b1.out_valid), 64'd0);
        chk("empty_buf_cnt", 64'(b1.buf_cnt), 64'd0);
        chk("empty_rd_en", 64'(b1.fifo_rd_en), 64'd0);

        // Flush with two buffered words and one in flight
        b1.out_ready = 1'b0;
        load1(32'h30, 5);
        repeat (4) tick();
        chk("pre_flush_cnt", 64'(b1.buf_cnt), 64'd2);
        chk("pre_flush_rd_en", 64'(b1.fifo_rd_en), 64'd0);
        flush1       = 1'b1;
        b1.out_ready = 1'b1;
        #1;
        chk("flush_rd_en", 64'(b1.fifo_rd_en), 64'd0);
        repeat (3) void'(exp1.pop_front());
        tick();
        flush1 = 1'b0;
        #1;
        chk("post_flush_cnt", 64'(b1.buf_cnt), 64'd0);
        chk("post_flush_valid", 64'(b1.out_valid), 64'd0);
        chk("post_flush_data", 64'(b1.out_data), 64'd0);
        chk("post_flush_resume", 64'(b1.fifo_rd_en), 64'd1);
        tick();
        chk("flush_pend_dropped", 64'(b1.buf_cnt), 64'd0);
        for (int i = 0; i < 20 && exp1.size() != 0; i++) tick();
        chk("flush_drained", 64'(exp1.size()), 64'd0);

        // RD_LAT=0, depth 2
        load0(32'hA0, 4);
        tick();
        chk("l0_first_rd_en", 64'(b0.fifo_rd_en), 64'd1);
        chk("l0_valid_n0", 64'(b0.out_valid), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b0.out_valid) vcnt++;
        end
        chk("l0_throughput", 64'(vcnt), 64'd4);
        tick();
        chk("l0_done_valid", 64'(b0.out_valid), 64'd0);
        chk("l0_drained", 64'(exp0.size()), 64'd0);

        // Asynchronous reset mid-stream
        load0(32'hB0, 6);
        repeat (3) tick();
        chk("l0_mid_valid", 64'(b0.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(b0.out_valid), 64'd0);
        chk("arst_cnt", 64'(b0.buf_cnt), 64'd0);
        chk("arst_data", 64'(b0.out_data), 64'd0);
        chk("arst_rd_en", 64'(b0.fifo_rd_en), 64'd0);
        exp0.delete();
        fq0.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_arst_valid", 64'(b0.out_valid), 64'd0);
        chk("post_arst_rd_en", 64'(b0.fifo_rd_en), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
